// File: rtl/rv32i_types.sv
// rv32i_types: shared opcode/funct3 encodings, memory FSM states and access size masks.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;
  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    ld  = 3'b011,
    lbu = 3'b100,
    lhu = 3'b101,
    lwu = 3'b110
  } load_funct3_t;
  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010,
    sd = 3'b011
  } store_funct3_t;
  typedef enum logic [1:0] {IDLE, REQ, DONE} mem_state_t;
  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    return sz == 2'd0 ? MASK_B : sz == 2'd1 ? MASK_H : sz == 2'd2 ? MASK_W : MASK_D;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the addressed bytes down to bit 0 and sign- or zero-extends them.
module lsu_load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [2:0]                 funct3,
  output logic [XLEN-1:0]            data
);
  logic [XLEN-1:0] s, keep;
  logic [6:0] nbits;
  logic msb;
  // keep ^ (keep >> 1) isolates the top bit of the loaded field, i.e. its sign bit
  always_comb begin
    s = rdata >> {offset, 3'b000};
    nbits = 7'd8 << funct3[1:0];
    keep = (nbits >= 7'(XLEN)) ? '1 : ~({XLEN{1'b1}} << nbits);
    msb = |(s & (keep ^ (keep >> 1)));
    data = (s & keep) | ({XLEN{~funct3[2] & msb}} & ~keep);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit issuing one aligned data-memory access per accepted op.
import rv32i_types::*;
module mem_access_unit #(
  parameter int XLEN = 32,
  parameter int STRB = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic [STRB-1:0] out_rmask,
  output logic [STRB-1:0] out_wmask,
  output logic            out_misaligned,
  output logic            out_illegal,
  output logic [XLEN-1:0] dmem_address,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [STRB-1:0] dmem_byte_enable,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_resp
);
  localparam int OFFW = $clog2(STRB);
  mem_state_t state, state_n;
  logic ld_r, st_r, mis_r, ill_r;
  logic [2:0] f3_r;
  logic [XLEN-1:0] addr_r, wdata_r, rdata_r, load_data;
  logic is_ld, is_st, ill, mis, go;
  logic [STRB-1:0] be_mask;
  // illegal funct3 is decided first: its size field is meaningless for alignment
  always_comb begin
    is_ld = in_opcode == op_load;
    is_st = in_opcode == op_store;
    ill = is_ld ? (in_funct3 == 3'b111 || (XLEN == 32 && (in_funct3 == ld || in_funct3 == lwu)))
        : is_st ? in_funct3 > ((XLEN == 32) ? sw : sd) : 1'b0;
    mis = (is_ld || is_st) && !ill && ((in_funct3[1:0] == 2'd1 && in_addr[0])
        || (in_funct3[1:0] == 2'd2 && |in_addr[1:0]) || (in_funct3[1:0] == 2'd3 && |in_addr[2:0]));
    go = (is_ld || is_st) && !ill && !mis;
  end
  always_comb begin
    state_n = state;
    in_ready = 1'b0;
    dmem_read = 1'b0;
    dmem_write = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        state_n = in_valid ? (go ? REQ : DONE) : IDLE;
      end
      REQ: begin
        dmem_read = ld_r;
        dmem_write = st_r;
        state_n = dmem_resp ? DONE : REQ;
      end
      DONE: begin
        out_valid = 1'b1;
        state_n = out_ready ? IDLE : DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ld_r <= 1'b0;
      st_r <= 1'b0;
      mis_r <= 1'b0;
      ill_r <= 1'b0;
      f3_r <= '0;
      addr_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        ld_r <= go & is_ld;
        st_r <= go & is_st;
        mis_r <= mis;
        ill_r <= ill;
        f3_r <= in_funct3;
        addr_r <= in_addr;
        wdata_r <= in_wdata;
        rdata_r <= '0;
      end
      if (state == REQ && dmem_resp && ld_r) rdata_r <= load_data;
    end
  end
  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata  (dmem_rdata),
    .offset (addr_r[OFFW-1:0]),
    .funct3 (f3_r),
    .data   (load_data)
  );
  always_comb begin
    be_mask = STRB'(size_mask(f3_r[1:0])) << addr_r[OFFW-1:0];
    dmem_address = {addr_r[XLEN-1:OFFW], {OFFW{1'b0}}};
    dmem_wdata = wdata_r << {addr_r[OFFW-1:0], 3'b000};
    dmem_byte_enable = (state == REQ && st_r) ? be_mask : '0;
    out_rmask = (state == DONE && ld_r) ? be_mask : '0;
    out_wmask = (state == DONE && st_r) ? be_mask : '0;
    out_misaligned = state == DONE && mis_r;
    out_illegal = state == DONE && ill_r;
    out_rdata = rdata_r;
  end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 SHALL have parameter STRB, default XLEN/8, byte-enable width; not overridden independently.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid in 1 and in_ready out 1; upstream handshake.
REQ-006 SHALL have ports in_opcode in 7, in_funct3 in 3, in_addr in XLEN, in_wdata in XLEN; operation, effective address, store data.
REQ-007 SHALL have ports out_valid out 1 and out_ready in 1; downstream handshake.
REQ-008 SHALL have ports out_rdata out XLEN (aligned, extended load result), out_rmask out STRB, out_wmask out STRB, out_misaligned out 1, out_illegal out 1.
REQ-009 SHALL have ports dmem_address out XLEN (STRB-aligned), dmem_read out 1, dmem_write out 1, dmem_wdata out XLEN, dmem_byte_enable out STRB.
REQ-010 SHALL have ports dmem_rdata in XLEN and dmem_resp in 1; cache returns data/acknowledges.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, DONE.
REQ-012 SHALL assert in_ready only in IDLE; accept when in_valid && in_ready.
REQ-013 SHALL on accepting op_load/op_store with legal, aligned funct3 go IDLE->REQ, registering opcode, funct3, address, data.
REQ-014 SHALL on accepting any other opcode go IDLE->DONE; out masks 0, out_rdata 0, no memory request.
REQ-015 SHALL flag misaligned: half offset[0]!=0; word offset[1:0]!=0; double (XLEN=64) offset[2:0]!=0; then IDLE->DONE, out_misaligned=1, masks 0, no request.
REQ-016 SHALL flag illegal funct3 (load 3'b011 when XLEN=32, 110/111; store >3'b010 when XLEN=32, >3'b011 when XLEN=64); then IDLE->DONE, out_illegal=1, no request.
REQ-017 SHALL in REQ drive dmem_read (load) or dmem_write (store) continuously, stable, until dmem_resp sampled high.
REQ-018 SHALL set dmem_address = address with low log2(STRB) bits zeroed.
REQ-019 SHALL set byte mask = (size mask) << offset: byte 1, half 3, word 4'hF, double 8'hFF; drive as dmem_byte_enable on stores, 0 on loads.
REQ-020 SHALL set dmem_wdata = store data << (8*offset).
REQ-021 SHALL on dmem_resp in REQ go REQ->DONE, capture (dmem_rdata >> 8*offset) sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu).
REQ-022 SHALL accept dmem_resp in first REQ cycle (one-cycle hit): latency accept->out_valid = 2 cycles.
REQ-023 SHALL in DONE assert out_valid with registered results held stable until out_ready; DONE->IDLE on out_valid && out_ready.
REQ-024 SHALL report out_rmask = byte mask for loads, out_wmask = byte mask for stores, other 0.
REQ-025 SHALL ignore dmem_resp in IDLE and DONE.

Reset
REQ-026 SHALL on rst enter IDLE; out_valid, dmem_read, dmem_write, out_misaligned, out_illegal = 0; out_rdata, masks, dmem_byte_enable = 0; in_ready=1 the cycle after.
REQ-027 SHALL on rst during REQ abandon request; dmem_read/dmem_write low next cycle; late dmem_resp ignored.
REQ-028 SHALL give rst priority over simultaneous in_valid, dmem_resp or out_ready.

Structure
REQ-029 SHALL add state enum mem_state_t and size-mask constants to rv32i_types; reuse existing opcode and load/store funct3 enums.
REQ-030 SHALL place shift-and-extend in combinational sub-module lsu_load_align, parametrised by XLEN.

Verification
REQ-031 SHALL test: XLEN=32, lb addr 0x1003, rdata 0x80FF_FFFF, resp 1st REQ cycle -> out_rdata 0xFFFF_FF80, rmask 4'b1000, out_valid 2 cycles post-accept.
REQ-032 SHALL test: sh addr 0x2002, wdata 0x0000_BEEF, resp delayed 5 cycles -> dmem_wdata 0xBEEF_0000, byte_enable 4'b1100 held 6 cycles, address 0x2000.
REQ-033 SHALL test: lw addr 0x3001 -> no dmem_read, out_misaligned=1, masks 0.
REQ-034 SHALL test: out_ready low 4 cycles in DONE -> outputs stable, in_ready 0, then IDLE.
REQ-035 SHALL test: rst during REQ, dmem_resp next cycle -> dmem_read 0, out_valid stays 0.
REQ-036 SHALL test: XLEN=64, lwu addr 0x4004, rdata 0x8765_4321_0000_0000 -> out_rdata 0x0000_0000_8765_4321, rmask 8'hF0.
